// File: rtl/bus_if_8008.sv
`default_nettype none
// ============================================================================
//  Module   : bus_if_8008
//  Purpose  : External bus interface for the 8008 core. Rebuilds the 14-bit
//             address and 2-bit cycle type from the T1/T2 bytes on the core's
//             multiplexed data output. Runs memory or I/O transactions on a
//             req/ack side bus, and returns read data to the core in T3.
//             It drives Ready low to insert WAIT states until read data is
//             available or the posted-write slot is free.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n          clock, asynchronous active-low reset
//    state               core T-state (WAIT/T1/T1I/T2/T3/T4/T5/STOPPED)
//    core_dout           core multiplexed address/data byte
//    core_din            data returned to the core (valid in T3 of reads)
//    ready               core Ready input (combinational)
//    cycle_type          latched cycle type (00 PCI, 10 PCR, 01 PCC, 11 PCW)
//    mem_addr/req/we/wdata, mem_rdata/ack    memory side bus
//    io_port/req/we/wdata,  io_rdata/ack     I/O side bus
//    intr_ack            (only with BUS_IF_INTR_JAM_EN) RST-jam pulse in T3
//  Build option
//    BUS_IF_INTR_JAM_EN  When defined, a PCI cycle that begins with T1I is
//                        answered with an RST instruction and does not
//                        access memory.
// ============================================================================
module bus_if_8008 #(
    parameter int         WIDTH      = 8,
    parameter int         ADDR_WIDTH = 14,
    parameter logic [2:0] RST_VEC    = 3'b000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            state,
    input  logic [WIDTH-1:0]      core_dout,
    output logic [WIDTH-1:0]      core_din,
    output logic                  ready,
    output logic [1:0]            cycle_type,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata,
    input  logic                  mem_ack,
    output logic [4:0]            io_port,
    output logic                  io_req,
    output logic                  io_we,
    output logic [WIDTH-1:0]      io_wdata,
    input  logic [WIDTH-1:0]      io_rdata,
    input  logic                  io_ack
`ifdef BUS_IF_INTR_JAM_EN
    ,
    output logic                  intr_ack
`endif
);

    localparam int HI_W = ADDR_WIDTH - WIDTH;

    // Core T-state encoding
    localparam logic [2:0] c_ST_WAIT = 3'b000;
    localparam logic [2:0] c_ST_T3   = 3'b001;
    localparam logic [2:0] c_ST_T1   = 3'b010;
    localparam logic [2:0] c_ST_T2   = 3'b100;
    localparam logic [2:0] c_ST_T1I  = 3'b110;

    // Cycle type encoding (T2 byte bits [7:6])
    localparam logic [1:0] c_CT_PCI = 2'b00;
    localparam logic [1:0] c_CT_PCR = 2'b10;
    localparam logic [1:0] c_CT_PCC = 2'b01;
    localparam logic [1:0] c_CT_PCW = 2'b11;

    localparam logic [WIDTH-1:0] c_JAM_BYTE = WIDTH'({2'b00, RST_VEC, 3'b101});

`ifdef BUS_IF_INTR_JAM_EN
    localparam logic c_JAM_EN = 1'b1;
`else
    localparam logic c_JAM_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        BI_IDLE  = 3'd0,
        BI_ADDR  = 3'd1,
        BI_RD    = 3'd2,
        BI_HOLD  = 3'd3,
        BI_WPEND = 3'd4
    } bi_state_t;

    // A cycle reads the bus if it is PCI, PCR or an INP (PCC with bits [5:4]==00)
    function automatic logic f_is_read(input logic [7:0] b);
        return (b[7:6] == c_CT_PCI) || (b[7:6] == c_CT_PCR) ||
               ((b[7:6] == c_CT_PCC) && (b[5:4] == 2'b00));
    endfunction

    bi_state_t         bi_state_d,  bi_state_q;
    logic [WIDTH-1:0]  addr_lo_d,   addr_lo_q;
    logic [HI_W-1:0]   addr_hi_d,   addr_hi_q;
    logic [1:0]        cycle_type_d, cycle_type_q;
    logic [WIDTH-1:0]  core_din_d,  core_din_q;
    logic              mem_req_d,   mem_req_q;
    logic              mem_we_d,    mem_we_q;
    logic [WIDTH-1:0]  mem_wdata_d, mem_wdata_q;
    logic [4:0]        io_port_d,   io_port_q;
    logic              io_req_d,    io_req_q;
    logic              io_we_d,     io_we_q;
    logic [WIDTH-1:0]  io_wdata_d,  io_wdata_q;
    logic              wr_armed_d,  wr_armed_q;   // PCW decoded, waiting for T3 data
    logic              intr_d,      intr_q;       // current cycle began with T1I
    logic [WIDTH-1:0]  shadow_lo_d, shadow_lo_q;  // T1 byte seen during a posted write
    logic              shadow_intr_d, shadow_intr_q;
    logic              t1_seen_d,   t1_seen_q;
    logic [WIDTH-1:0]  shadow_hi_d, shadow_hi_q;  // T2 byte seen during a posted write
    logic              pend_d,      pend_q;       // shadow_hi holds a decoded T2
`ifdef BUS_IF_INTR_JAM_EN
    logic              intr_ack_d,  intr_ack_q;
`endif

    logic              w_is_t1;
    logic              w_ack_hit;
    logic              w_launch;
    logic [WIDTH-1:0]  w_launch_hi;
    logic              w_jam;

    assign w_is_t1     = (state == c_ST_T1) || (state == c_ST_T1I);
    assign w_ack_hit   = (mem_req_q && mem_ack) || (io_req_q && io_ack);
    // A T2 that arrived during a posted write is replayed from the shadow
    assign w_launch_hi = pend_q ? shadow_hi_q : core_dout;
    assign w_jam       = c_JAM_EN && intr_q && (w_launch_hi[7:6] == c_CT_PCI);
    assign w_launch    = (bi_state_q == BI_ADDR) && (pend_q || (state == c_ST_T2));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        bi_state_d    = bi_state_q;
        addr_lo_d     = addr_lo_q;
        addr_hi_d     = addr_hi_q;
        cycle_type_d  = cycle_type_q;
        core_din_d    = core_din_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_wdata_d   = mem_wdata_q;
        io_port_d     = io_port_q;
        io_req_d      = io_req_q;
        io_we_d       = io_we_q;
        io_wdata_d    = io_wdata_q;
        wr_armed_d    = wr_armed_q;
        intr_d        = intr_q;
        shadow_lo_d   = shadow_lo_q;
        shadow_intr_d = shadow_intr_q;
        t1_seen_d     = t1_seen_q;
        shadow_hi_d   = shadow_hi_q;
        pend_d        = pend_q;
`ifdef BUS_IF_INTR_JAM_EN
        intr_ack_d    = 1'b0;
`endif

        unique case (bi_state_q)
            BI_IDLE: begin
                if (w_is_t1) begin
                    addr_lo_d  = core_dout;
                    intr_d     = (state == c_ST_T1I);
                    wr_armed_d = 1'b0;
                    bi_state_d = BI_ADDR;
                end else if ((state == c_ST_T3) && wr_armed_q) begin
                    mem_wdata_d = core_dout;
                    mem_we_d    = 1'b1;
                    mem_req_d   = 1'b1;
                    wr_armed_d  = 1'b0;
                    bi_state_d  = BI_WPEND;
                end else if (state == c_ST_T3) begin
                    core_din_d = '0;
                end
            end

            BI_ADDR: begin
                // T2 decode is handled by the launch block below
                if (!w_launch && w_is_t1) begin
                    addr_lo_d = core_dout;
                    intr_d    = (state == c_ST_T1I);
                end
            end

            BI_RD: begin
                if (w_ack_hit) begin
                    core_din_d = mem_req_q ? mem_rdata : io_rdata;
                    mem_req_d  = 1'b0;
                    io_req_d   = 1'b0;
                    bi_state_d = BI_HOLD;
                end
            end

            BI_HOLD: begin
                // Data stays up through the WAIT/T3 that follow the ack
                if (w_is_t1) begin
                    core_din_d = '0;
                    addr_lo_d  = core_dout;
                    intr_d     = (state == c_ST_T1I);
                    bi_state_d = BI_ADDR;
                end else if ((state != c_ST_WAIT) && (state != c_ST_T3)) begin
                    core_din_d = '0;
                    bi_state_d = BI_IDLE;
                end
            end

            BI_WPEND: begin
                // The core runs ahead; park its next T1/T2 bytes so the
                // bus address and data stay stable until the ack.
                if (w_is_t1) begin
                    shadow_lo_d   = core_dout;
                    shadow_intr_d = (state == c_ST_T1I);
                    t1_seen_d     = 1'b1;
                end else if ((state == c_ST_T2) && t1_seen_q && !pend_q) begin
                    shadow_hi_d = core_dout;
                    pend_d      = 1'b1;
                end

                if (w_ack_hit) begin
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    io_req_d   = 1'b0;
                    io_we_d    = 1'b0;
                    bi_state_d = BI_IDLE;
                    if (w_is_t1) begin
                        addr_lo_d  = core_dout;
                        intr_d     = (state == c_ST_T1I);
                        t1_seen_d  = 1'b0;
                        bi_state_d = BI_ADDR;
                    end else if (t1_seen_q) begin
                        // Requests drop for one clk before any replayed cycle
                        addr_lo_d  = shadow_lo_q;
                        intr_d     = shadow_intr_q;
                        t1_seen_d  = 1'b0;
                        bi_state_d = BI_ADDR;
                    end
                end
            end

            default: begin
                bi_state_d = BI_IDLE;
            end
        endcase

        // T2 decode: latch the address/type and start the transaction
        if (w_launch) begin
            pend_d       = 1'b0;
            addr_hi_d    = w_launch_hi[HI_W-1:0];
            cycle_type_d = w_launch_hi[7:6];
            if (w_jam) begin
                core_din_d = c_JAM_BYTE;
                bi_state_d = BI_HOLD;
`ifdef BUS_IF_INTR_JAM_EN
                intr_ack_d = 1'b1;
`endif
            end else begin
                unique case (w_launch_hi[7:6])
                    c_CT_PCC: begin
                        io_port_d  = w_launch_hi[5:1];
                        io_we_d    = (w_launch_hi[5:4] != 2'b00);
                        io_wdata_d = addr_lo_q;
                        io_req_d   = 1'b1;
                        bi_state_d = (w_launch_hi[5:4] != 2'b00) ? BI_WPEND : BI_RD;
                    end
                    c_CT_PCW: begin
                        wr_armed_d = 1'b1;
                        bi_state_d = BI_IDLE;
                    end
                    default: begin
                        mem_we_d   = 1'b0;
                        mem_req_d  = 1'b1;
                        bi_state_d = BI_RD;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Ready: stall the core while read data or the write slot is not ready
    // ------------------------------------------------------------------
    always_comb begin
        ready = 1'b1;
        unique case (bi_state_q)
            BI_ADDR: begin
                if (pend_q) begin
                    ready = 1'b0;
                end else if ((state == c_ST_T2) && f_is_read(core_dout[7:0]) && !w_jam) begin
                    ready = 1'b0;
                end
            end
            BI_RD: begin
                if (state == c_ST_WAIT) begin
                    ready = 1'b0;
                end
            end
            BI_WPEND: begin
                if ((state == c_ST_T2) || (state == c_ST_WAIT)) begin
                    ready = 1'b0;
                end
            end
            default: begin
                ready = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bi_state_q    <= BI_IDLE;
            addr_lo_q     <= '0;
            addr_hi_q     <= '0;
            cycle_type_q  <= '0;
            core_din_q    <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= '0;
            io_port_q     <= '0;
            io_req_q      <= 1'b0;
            io_we_q       <= 1'b0;
            io_wdata_q    <= '0;
            wr_armed_q    <= 1'b0;
            intr_q        <= 1'b0;
            shadow_lo_q   <= '0;
            shadow_intr_q <= 1'b0;
            t1_seen_q     <= 1'b0;
            shadow_hi_q   <= '0;
            pend_q        <= 1'b0;
`ifdef BUS_IF_INTR_JAM_EN
            intr_ack_q    <= 1'b0;
`endif
        end else begin
            bi_state_q    <= bi_state_d;
            addr_lo_q     <= addr_lo_d;
            addr_hi_q     <= addr_hi_d;
            cycle_type_q  <= cycle_type_d;
            core_din_q    <= core_din_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_wdata_q   <= mem_wdata_d;
            io_port_q     <= io_port_d;
            io_req_q      <= io_req_d;
            io_we_q       <= io_we_d;
            io_wdata_q    <= io_wdata_d;
            wr_armed_q    <= wr_armed_d;
            intr_q        <= intr_d;
            shadow_lo_q   <= shadow_lo_d;
            shadow_intr_q <= shadow_intr_d;
            t1_seen_q     <= t1_seen_d;
            shadow_hi_q   <= shadow_hi_d;
            pend_q        <= pend_d;
`ifdef BUS_IF_INTR_JAM_EN
            intr_ack_q    <= intr_ack_d;
`endif
        end
    end

    assign core_din   = core_din_q;
    assign cycle_type = cycle_type_q;
    assign mem_addr   = {addr_hi_q, addr_lo_q};
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign io_port    = io_port_q;
    assign io_req     = io_req_q;
    assign io_we      = io_we_q;
    assign io_wdata   = io_wdata_q;
`ifdef BUS_IF_INTR_JAM_EN
    assign intr_ack   = intr_ack_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_if_8008.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_if_8008
//  Purpose  : Directed self-checking bench for bus_if_8008 (fetch, posted
//             write with a following stalled cycle, INP, OUT, T1I, reset).
//  Revision : 1.0  initial release
// ============================================================================
module tb_bus_if_8008;

    localparam logic [2:0] c_WAIT = 3'b000;
    localparam logic [2:0] c_T3   = 3'b001;
    localparam logic [2:0] c_T1   = 3'b010;
    localparam logic [2:0] c_STOP = 3'b011;
    localparam logic [2:0] c_T2   = 3'b100;
    localparam logic [2:0] c_T1I  = 3'b110;
    localparam logic [2:0] c_T4   = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  state;
    logic [7:0]  core_dout;
    logic [7:0]  core_din;
    logic        ready;
    logic [1:0]  cycle_type;
    logic [13:0] mem_addr;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [4:0]  io_port;
    logic        io_req;
    logic        io_we;
    logic [7:0]  io_wdata;
    logic [7:0]  io_rdata;
    logic        io_ack;
`ifdef BUS_IF_INTR_JAM_EN
    logic        intr_ack;
`endif

    int n_checks = 0;
    int n_errors = 0;

    bus_if_8008 #(
        .WIDTH      (8),
        .ADDR_WIDTH (14),
        .RST_VEC    (3'b111)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .state      (state),
        .core_dout  (core_dout),
        .core_din   (core_din),
        .ready      (ready),
        .cycle_type (cycle_type),
        .mem_addr   (mem_addr),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .io_port    (io_port),
        .io_req     (io_req),
        .io_we      (io_we),
        .io_wdata   (io_wdata),
        .io_rdata   (io_rdata),
        .io_ack     (io_ack)
`ifdef BUS_IF_INTR_JAM_EN
        ,
        .intr_ack   (intr_ack)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a core state/byte and let combinational outputs settle
    task automatic drive(input logic [2:0] st, input logic [7:0] d);
        state     = st;
        core_dout = d;
        #1;
    endtask

    // Advance through one rising edge and settle past it
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n     = 1'b0;
        state     = c_STOP;
        core_dout = 8'h00;
        mem_rdata = 8'h00;
        mem_ack   = 1'b0;
        io_rdata  = 8'h00;
        io_ack    = 1'b0;
        #1;
        check("rst_ready",    32'(ready),      32'h1);
        check("rst_mem_req",  32'(mem_req),    32'h0);
        check("rst_io_req",   32'(io_req),     32'h0);
        check("rst_core_din", 32'(core_din),   32'h0);
        check("rst_mem_addr", 32'(mem_addr),   32'h0);
        check("rst_ctype",    32'(cycle_type), 32'h0);
        step();
        step();
        rst_n = 1'b1;

        // ---------------- Fetch (PCI) ----------------
        drive(c_T1, 8'h34);
        check("fetch_t1_ready", 32'(ready), 32'h1);
        step();
        drive(c_T2, 8'h12);
        check("fetch_t2_ready", 32'(ready), 32'h0);
        step();
        check("fetch_addr",    32'(mem_addr),   32'h1234);
        check("fetch_req",     32'(mem_req),    32'h1);
        check("fetch_we",      32'(mem_we),     32'h0);
        check("fetch_io_req",  32'(io_req),     32'h0);
        check("fetch_ctype",   32'(cycle_type), 32'h0);
        drive(c_WAIT, 8'h00);
        check("fetch_wait_ready", 32'(ready), 32'h0);
        step();
        drive(c_WAIT, 8'h00);
        step();
        drive(c_WAIT, 8'h00);
        mem_rdata = 8'hC7;
        mem_ack   = 1'b1;
        check("fetch_req_held", 32'(mem_req), 32'h1);
        step();
        mem_ack = 1'b0;
        check("fetch_req_drop", 32'(mem_req),  32'h0);
        check("fetch_din",      32'(core_din), 32'hC7);
        drive(c_WAIT, 8'h00);
        check("fetch_hold_ready", 32'(ready), 32'h1);
        step();
        drive(c_T3, 8'h00);
        check("fetch_t3_din", 32'(core_din), 32'hC7);
        step();
        drive(c_T4, 8'h00);
        step();
        check("fetch_din_clr", 32'(core_din), 32'h0);

        // Stray ack with no request outstanding must be ignored
        mem_rdata = 8'hFF;
        mem_ack   = 1'b1;
        step();
        mem_ack = 1'b0;
        check("stray_ack_din", 32'(core_din), 32'h0);
        check("stray_ack_req", 32'(mem_req),  32'h0);

        // ---------------- T1I cycle ----------------
        drive(c_T1I, 8'h00);
        step();
        drive(c_T2, 8'h00);
`ifdef BUS_IF_INTR_JAM_EN
        check("jam_t2_ready", 32'(ready), 32'h1);
        step();
        check("jam_no_req", 32'(mem_req), 32'h0);
        drive(c_T3, 8'h00);
        check("jam_din",      32'(core_din), 32'h3D);
        check("jam_intr_ack", 32'(intr_ack), 32'h1);
        step();
        check("jam_intr_ack_clr", 32'(intr_ack), 32'h0);
        drive(c_T4, 8'h00);
        step();
        check("jam_din_clr", 32'(core_din), 32'h0);
`else
        check("t1i_t2_ready", 32'(ready), 32'h0);
        step();
        check("t1i_req",  32'(mem_req),  32'h1);
        check("t1i_addr", 32'(mem_addr), 32'h0000);
        drive(c_WAIT, 8'h00);
        mem_rdata = 8'h55;
        mem_ack   = 1'b1;
        step();
        mem_ack = 1'b0;
        check("t1i_req_drop", 32'(mem_req), 32'h0);
        drive(c_WAIT, 8'h00);
        step();
        drive(c_T3, 8'h00);
        check("t1i_din", 32'(core_din), 32'h55);
        step();
        drive(c_T4, 8'h00);
        step();
`endif

        // ---------------- Posted write (PCW) ----------------
        drive(c_T1, 8'h00);
        step();
        drive(c_T2, 8'hFF);
        check("wr_t2_ready", 32'(ready), 32'h1);
        step();
        check("wr_addr",     32'(mem_addr),   32'h3F00);
        check("wr_ctype",    32'(cycle_type), 32'h3);
        check("wr_no_req",   32'(mem_req),    32'h0);
        drive(c_T3, 8'h5A);
        check("wr_t3_ready", 32'(ready), 32'h1);
        step();
        check("wr_req",   32'(mem_req),   32'h1);
        check("wr_we",    32'(mem_we),    32'h1);
        check("wr_wdata", 32'(mem_wdata), 32'h5A);
        // Next cycle starts before the ack
        drive(c_T1, 8'h77);
        check("wr_next_t1_ready", 32'(ready), 32'h1);
        step();
        check("wr_addr_stable", 32'(mem_addr), 32'h3F00);
        check("wr_req_held",    32'(mem_req),  32'h1);
        drive(c_T2, 8'h05);
        check("wr_next_t2_ready", 32'(ready), 32'h0);
        step();
        drive(c_WAIT, 8'h00);
        check("wr_wait_ready", 32'(ready),     32'h0);
        check("wr_wdata_held", 32'(mem_wdata), 32'h5A);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("wr_req_drop", 32'(mem_req), 32'h0);
        check("wr_we_drop",  32'(mem_we),  32'h0);
        drive(c_WAIT, 8'h00);
        check("rd2_wait_ready", 32'(ready), 32'h0);
        step();
        check("rd2_req",  32'(mem_req),  32'h1);
        check("rd2_we",   32'(mem_we),   32'h0);
        check("rd2_addr", 32'(mem_addr), 32'h0577);
        drive(c_WAIT, 8'h00);
        check("rd2_ready", 32'(ready), 32'h0);
        mem_rdata = 8'h21;
        mem_ack   = 1'b1;
        step();
        mem_ack = 1'b0;
        check("rd2_din", 32'(core_din), 32'h21);
        drive(c_WAIT, 8'h00);
        step();
        drive(c_T3, 8'h00);
        check("rd2_t3_din", 32'(core_din), 32'h21);
        step();
        drive(c_T4, 8'h00);
        step();

        // ---------------- INP ----------------
        drive(c_T1, 8'h11);
        step();
        drive(c_T2, 8'h4B);
        check("inp_t2_ready", 32'(ready), 32'h0);
        step();
        check("inp_port",    32'(io_port),    32'h05);
        check("inp_we",      32'(io_we),      32'h0);
        check("inp_req",     32'(io_req),     32'h1);
        check("inp_mem_req", 32'(mem_req),    32'h0);
        check("inp_ctype",   32'(cycle_type), 32'h1);
        drive(c_WAIT, 8'h00);
        io_rdata = 8'h9E;
        io_ack   = 1'b1;
        step();
        io_ack = 1'b0;
        check("inp_req_drop", 32'(io_req),   32'h0);
        check("inp_din",      32'(core_din), 32'h9E);
        drive(c_WAIT, 8'h00);
        step();
        drive(c_T3, 8'h00);
        check("inp_t3_din", 32'(core_din), 32'h9E);
        step();
        drive(c_T4, 8'h00);
        step();
        check("inp_din_clr", 32'(core_din), 32'h0);

        // ---------------- OUT ----------------
        drive(c_T1, 8'hA5);
        step();
        drive(c_T2, 8'h53);
        check("out_t2_ready", 32'(ready), 32'h1);
        step();
        check("out_req",   32'(io_req),   32'h1);
        check("out_we",    32'(io_we),    32'h1);
        check("out_wdata", 32'(io_wdata), 32'hA5);
        check("out_port",  32'(io_port),  32'h09);
        check("out_no_mem",32'(mem_req),  32'h0);
        drive(c_T3, 8'h00);
        check("out_t3_ready", 32'(ready), 32'h1);
        step();
        drive(c_T4, 8'h00);
        check("out_req_held", 32'(io_req), 32'h1);
        io_ack = 1'b1;
        step();
        io_ack = 1'b0;
        check("out_req_drop", 32'(io_req), 32'h0);
        check("out_we_drop",  32'(io_we),  32'h0);

        // ---------------- Reset mid-read ----------------
        drive(c_T1, 8'h34);
        step();
        drive(c_T2, 8'h12);
        step();
        check("mrst_req_pre", 32'(mem_req), 32'h1);
        drive(c_WAIT, 8'h00);
        step();
        rst_n = 1'b0;
        #1;
        check("mrst_req",   32'(mem_req),  32'h0);
        check("mrst_din",   32'(core_din), 32'h0);
        check("mrst_ready", 32'(ready),    32'h1);
        step();
        step();
        rst_n = 1'b1;
        drive(c_WAIT, 8'h00);
        step();
        step();
        check("mrst_post_req",    32'(mem_req), 32'h0);
        check("mrst_post_io_req", 32'(io_req),  32'h0);
        check("mrst_post_ready",  32'(ready),   32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_if_8008.md
Name: bus_if_8008

Overview:
- External bus interface that sits directly downstream of the 8008 core.
- Watches the core's T-state output and multiplexed data byte, and reassembles the 14-bit address and 2-bit cycle type from T1/T2.
- Issues memory or I/O transactions on a simple req/ack side bus and returns read data to the core in T3.
- Drives the core's Ready input, inserting WAIT states until read data is available or a posted write slot is free.

Parameters:
- WIDTH, 8, data byte width.
- ADDR_WIDTH, 14, memory address width.
- RST_VEC, 3'b000, RST vector jammed on interrupt acknowledge (used only with the optional feature).

Ports:
- clk  in  1  system clock; one T-state per clk except WAIT/STOPPED.
- rst_n  in  1  asynchronous active-low reset.
- state  in  3  core state_t: WAIT=000, T3=001, T1=010, STOPPED=011, T2=100, T5=101, T1I=110, T4=111.
- core_dout  in  WIDTH  core data output (multiplexed address/data).
- core_din  out  WIDTH  data to core; valid in T3 of read/INP cycles.
- ready  out  1  to core Ready; combinational.
- cycle_type  out  2  latched cycle type: 00 PCI, 10 PCR, 01 PCC, 11 PCW.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 = write.
- mem_wdata  out  WIDTH  write data.
- mem_rdata  in  WIDTH  read data; valid with mem_ack.
- mem_ack  in  1  one-cycle acknowledge.
- io_port  out  5  I/O port number (instruction bits [5:1]).
- io_req  out  1  I/O request; held until io_ack.
- io_we  out  1  1 = OUT, 0 = INP.
- io_wdata  out  WIDTH  OUT data (accumulator byte from T1).
- io_rdata  in  WIDTH  INP data; valid with io_ack.
- io_ack  in  1  one-cycle acknowledge.

Behaviour:
- Reset: all outputs 0 except ready=1. Internal FSM is BI_IDLE. Pending transactions are dropped, with no req on release. Reset takes effect immediately, mid-transaction included.
- Internal FSM states: BI_IDLE, BI_ADDR (T1 captured), BI_RD (read/INP outstanding), BI_HOLD (read data valid), BI_WPEND (write/OUT outstanding).
- Clock with state==T1 or T1I: register core_dout as addr_lo; go to BI_ADDR.
- Clock with state==T2 in BI_ADDR: register addr_hi=core_dout[5:0] and cycle_type=core_dout[7:6].
  - mem_addr = {addr_hi, addr_lo}.
  - For PCC: io_port=core_dout[5:1]; io_we=1 iff core_dout[5:4]!=00; io_wdata=addr_lo.
  - PCI/PCR, or PCC with INP: go to BI_RD. mem_req (or io_req) rises the next clk.
  - PCC OUT: go to BI_WPEND; io_req rises the next clk.
  - PCW: return to BI_IDLE.
- ready:
  - 0 in T2 when the decoded type is read/INP.
  - 0 in T2/WAIT when a previous write is still pending.
  - 0 in WAIT while in BI_RD.
  - 1 otherwise.
  - Minimum read latency is therefore one WAIT state.
- BI_RD: on ack, register rdata into core_din, drop req the same edge, go to BI_HOLD. core_din holds until the clk where state leaves T3, then clears to 0; go to BI_IDLE.
- PCW: on the clk with state==T3, register mem_wdata=core_dout and mem_we=1; mem_req rises the next clk; go to BI_WPEND.
- BI_WPEND: req held, address/data stable, until ack; then req=0, we=0, go to BI_IDLE. The core may proceed (posted write).
  - A new T1 during BI_WPEND captures addr_lo into a shadow register without disturbing mem_addr.
  - The following T2 holds ready=0 until the ack.
- Request/ack: req never drops before ack; ack while req=0 is ignored. mem_* and io_* are never requested simultaneously.
- STOPPED/T4/T5: no new transaction; an outstanding write still completes.
- Unexpected state (e.g. T3 in BI_IDLE for a read type): no transaction, core_din=0.

Optional Feature:
- Macro: BUS_IF_INTR_JAM_EN.
- Defined: a PCI cycle begun with T1I issues no mem_req. core_din = {2'b00, RST_VEC, 3'b101} (an RST instruction) in T3. ready is 1 in T2 (no WAIT). Output intr_ack (1 bit) pulses one clk during that T3.
- Undefined: T1I is treated exactly as T1 (normal memory fetch), and there is no intr_ack port.

Test Plan:
- Fetch: T1 dout=8'h34, T2 dout=8'h12 (PCI) → mem_addr=14'h1234, mem_req next clk, ready=0. mem_ack with rdata=8'hC7 after 3 clks → one extra WAIT then T3, core_din=8'hC7; req drops on the ack edge.
- Write: T1 8'h00, T2 8'hFF (PCW, addr 14'h3F00), T3 dout=8'h5A → ready stays 1; mem_req/mem_we/mem_wdata=8'h5A held until ack. A next T2 issued before the ack sees ready=0 until the ack.
- INP: T1 8'h11, T2 8'h4B (PCC, port 5) → io_port=5, io_we=0, io_req. io_ack with 8'h9E → core_din=8'h9E in T3.
- OUT: T1 8'hA5, T2 8'h53 (PCC, port 5'h09) → io_we=1, io_wdata=8'hA5, ready=1 throughout.
- Reset: assert rst_n=0 with mem_req high mid-read → mem_req=0, core_din=0, ready=1 immediately; no req after release until a new T1/T2.
- With BUS_IF_INTR_JAM_EN and RST_VEC=3'b111: T1I, T2 dout=8'h00 → no mem_req, ready=1, core_din=8'h3D in T3, intr_ack pulse.
